// File: rtl/stack_controller_pkg.sv
// Shared CPU-side definitions for the stack controller.
//   SP_TOP_DEF    : empty-stack SP value (also the SP reset value)
//   SP_BOTTOM_DEF : lowest legal SP, reached when the stack is full
//   state_t       : controller state encoding
package stack_controller_pkg;

   localparam logic [31:0] SP_TOP_DEF    = 32'd111;
   localparam logic [31:0] SP_BOTTOM_DEF = 32'd64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_READ   = 3'd2,
      ST_RDWAIT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/stack_controller.sv
// Stack push/pop sequencer. The stack grows downward in a word-addressed
// data memory: PUSH writes mem[SP-1] and then sets SP = SP-1; POP reads
// mem[SP] and then sets SP = SP+1. A shadow copy of SP is kept in sp_cur and
// updated on the same edge that the register bank samples stack_op.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req_valid/pop/data    : request (pop=1 POP, pop=0 PUSH), data for PUSH
//   req_ready             : high only in IDLE, low while reset is asserted
//   stack_op, sp_next     : one-cycle SP commit strobe and new SP value
//   mem_addr/wdata/we/re  : data-memory port; mem_rdata valid cycle after re
//   resp_valid/data/err   : one-cycle completion, POP data, over/underflow
//   sp_cur                : current shadow SP
//
// state  | meaning
// IDLE   | ready for a request
// WRITE  | PUSH: write memory and commit SP-1
// READ   | POP: read strobe at SP
// RDWAIT | POP: capture read data and commit SP+1
// DONE   | response pulse, then back to IDLE
module stack_controller
   import stack_controller_pkg::*;
#(
   parameter logic [31:0] SP_TOP    = SP_TOP_DEF,
   parameter logic [31:0] SP_BOTTOM = SP_BOTTOM_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_pop,
   input  logic [31:0] req_data,
   output logic        req_ready,
   output logic        stack_op,
   output logic [31:0] sp_next,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [31:0] sp_cur
);

   state_t      state, state_nxt;
   logic [31:0] data_q;
   logic [31:0] sp_q;
   logic        err_q;
   logic        req_err;

   // Request would run off either end of the stack.
   assign req_err = req_pop ? (sp_cur >= SP_TOP) : (sp_cur <= SP_BOTTOM);

   // Strobes are forced low while reset is high so an aborted request
   // cannot leak a memory access or SP commit.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      stack_op   = 1'b0;
      sp_next    = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               req_ready = 1'b1;
               if (req_valid) begin
                  if (req_err)      state_nxt = ST_DONE;
                  else if (req_pop) state_nxt = ST_READ;
                  else              state_nxt = ST_WRITE;
               end
            end
            ST_WRITE: begin
               mem_we    = 1'b1;
               mem_addr  = sp_q - 32'd1;
               mem_wdata = data_q;
               stack_op  = 1'b1;
               sp_next   = sp_q - 32'd1;
               state_nxt = ST_DONE;
            end
            ST_READ: begin
               mem_re    = 1'b1;
               mem_addr  = sp_q;
               state_nxt = ST_RDWAIT;
            end
            ST_RDWAIT: begin
               stack_op  = 1'b1;
               sp_next   = sp_q + 32'd1;
               state_nxt = ST_DONE;
            end
            ST_DONE: begin
               resp_valid = 1'b1;
               resp_err   = err_q;
               state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         sp_cur    <= SP_TOP;
         resp_data <= '0;
         data_q    <= '0;
         sp_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (stack_op) sp_cur <= sp_next;
         if (state == ST_IDLE && req_valid) begin
            data_q <= req_data;
            sp_q   <= sp_cur;
            err_q  <= req_err;
            // Overflowed PUSH goes straight to DONE; its response data is 0.
            if (req_err && !req_pop) resp_data <= '0;
         end
         // resp_data only changes on the edge entering DONE, so it holds
         // its value whenever resp_valid is low.
         if (state == ST_WRITE)  resp_data <= '0;
         if (state == ST_RDWAIT) resp_data <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
module tb_stack_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_pop;
   logic [31:0] req_data;
   logic        req_ready;
   logic        stack_op;
   logic [31:0] sp_next;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [31:0] sp_cur;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   stack_controller dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_pop    (req_pop),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .stack_op   (stack_op),
      .sp_next    (sp_next),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .sp_cur     (sp_cur)
   );

   // Synchronous data memory: read data appears the cycle after mem_re.
   logic [31:0] mem [0:127];
   always @(posedge clock) begin
      if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[6:0]];
   end

   typedef struct {
      logic        pop;
      logic [31:0] data;
      logic        err;
      logic [31:0] addr;
      logic [31:0] sp_after;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the
   // first idle cycle after the response.
   task automatic run_req(input logic pop, input logic [31:0] data, input logic err,
                          input logic [31:0] addr, input logic [31:0] sp_after,
                          input logic [31:0] rdata);
      check("ready_before", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_pop   = pop;
      req_data  = data;
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(negedge clock);
      if (err) begin
         check("err_resp_valid", {31'd0, resp_valid}, 32'd1);
         check("err_resp_err", {31'd0, resp_err}, 32'd1);
         check("err_no_strobe", {29'd0, mem_we, mem_re, stack_op}, 32'd0);
      end else if (!pop) begin
         check("push_we", {31'd0, mem_we}, 32'd1);
         check("push_addr", mem_addr, addr);
         check("push_wdata", mem_wdata, data);
         check("push_stack_op", {31'd0, stack_op}, 32'd1);
         check("push_sp_next", sp_next, sp_after);
         check("push_no_resp", {31'd0, resp_valid}, 32'd0);
         @(negedge clock);
         check("push_resp_valid", {31'd0, resp_valid}, 32'd1);
         check("push_resp_err", {31'd0, resp_err}, 32'd0);
         check("push_resp_data", resp_data, 32'd0);
         check("push_done_quiet", {30'd0, mem_we, stack_op}, 32'd0);
      end else begin
         check("pop_re", {31'd0, mem_re}, 32'd1);
         check("pop_addr", mem_addr, addr);
         check("pop_early_op", {30'd0, stack_op, resp_valid}, 32'd0);
         @(negedge clock);
         check("pop_stack_op", {31'd0, stack_op}, 32'd1);
         check("pop_sp_next", sp_next, sp_after);
         check("pop_re_once", {31'd0, mem_re}, 32'd0);
         @(negedge clock);
         check("pop_resp_valid", {31'd0, resp_valid}, 32'd1);
         check("pop_resp_err", {31'd0, resp_err}, 32'd0);
         check("pop_resp_data", resp_data, rdata);
         check("pop_done_quiet", {31'd0, stack_op}, 32'd0);
      end
      @(negedge clock);
      check("sp_after", sp_cur, sp_after);
      check("idle_no_resp", {31'd0, resp_valid}, 32'd0);
      if (!err && pop) check("resp_data_hold", resp_data, rdata);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'hDEADBEEF, 1'b0, 32'd110, 32'd110, 32'd0};
      vecs[1] = '{1'b1, 32'h0,        1'b0, 32'd110, 32'd111, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h0,        1'b1, 32'd0,   32'd111, 32'd0};
      vecs[3] = '{1'b0, 32'h11111111, 1'b0, 32'd110, 32'd110, 32'd0};
      vecs[4] = '{1'b0, 32'h22222222, 1'b0, 32'd109, 32'd109, 32'd0};
      vecs[5] = '{1'b1, 32'h0,        1'b0, 32'd109, 32'd110, 32'h22222222};
      vecs[6] = '{1'b1, 32'h0,        1'b0, 32'd110, 32'd111, 32'h11111111};
      vecs[7] = '{1'b1, 32'h0,        1'b1, 32'd0,   32'd111, 32'd0};

      reset     = 1'b1;
      req_valid = 1'b0;
      req_pop   = 1'b0;
      req_data  = '0;
      repeat (3) @(negedge clock);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_sp", sp_cur, 32'd111);
      check("rst_strobes", {28'd0, stack_op, mem_we, mem_re, resp_valid}, 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_sp_next", sp_next, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 8; i++)
         run_req(vecs[i].pop, vecs[i].data, vecs[i].err, vecs[i].addr,
                 vecs[i].sp_after, vecs[i].rdata);

      // Fill the stack: 47 pushes take SP from 111 down to 64.
      for (int i = 0; i < 47; i++)
         run_req(1'b0, 32'hC000_0000 + i, 1'b0, 32'd110 - i, 32'd110 - i, 32'd0);
      run_req(1'b0, 32'h0BAD_0BAD, 1'b1, 32'd0, 32'd64, 32'd0);
      run_req(1'b1, 32'h0, 1'b0, 32'd64, 32'd65, 32'hC000_002E);

      // Reset during the READ cycle of a POP.
      req_valid = 1'b1;
      req_pop   = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      check("abort_no_op", {30'd0, stack_op, mem_re}, 32'd0);
      check("abort_ready_low", {31'd0, req_ready}, 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("abort_after_strobes", {28'd0, stack_op, mem_we, mem_re, resp_valid}, 32'd0);
      check("abort_sp", sp_cur, 32'd111);
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check("abort_no_resp", {30'd0, resp_valid, stack_op}, 32'd0);
      end

      // req_valid held high: PUSHes accepted every third cycle.
      req_valid = 1'b1;
      req_pop   = 1'b0;
      req_data  = 32'h5A5A_0000;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clock);
         check("b2b_ready", {31'd0, req_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
         check("b2b_we", {31'd0, mem_we}, (c % 3 == 1) ? 32'd1 : 32'd0);
      end
      req_valid = 1'b0;
      @(negedge clock);
      check("b2b_sp", sp_cur, 32'd108);
      check("b2b_idle", {31'd0, req_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
